// File: rtl/mem_stage_pkg.sv
// Shared encodings for the MEM pipeline stage: access sizes, FSM states and
// the default bus timeout.
package mem_stage_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam int TIMEOUT_DEFAULT = 255;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mem_state_t;

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane steering for the MEM stage (little-endian).
// Stores: byte enables and lane-replicated write data.
// Loads : lane extract plus zero/sign extension. Size 2'b11 behaves as word.
module mem_lane_align
    import mem_stage_pkg::*;
(
    input  logic [1:0]  byte_off,
    input  logic [1:0]  size,
    input  logic        is_signed,
    input  logic [31:0] store_data,
    input  logic [31:0] load_word,
    output logic        misaligned,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] load_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Decode size/offset into enables, replicated store data and formatted load.
    always_comb begin
        misaligned = 1'b0;
        be         = 4'b1111;
        wdata      = store_data;
        load_data  = load_word;
        byte_sel   = load_word[{byte_off, 3'b000} +: 8];
        half_sel   = load_word[{byte_off[1], 4'b0000} +: 16];
        case (size)
            SZ_BYTE: begin
                be        = 4'b0001 << byte_off;
                wdata     = {4{store_data[7:0]}};
                load_data = {{24{is_signed & byte_sel[7]}}, byte_sel};
            end
            SZ_HALF: begin
                misaligned = byte_off[0];
                be         = byte_off[1] ? 4'b1100 : 4'b0011;
                wdata      = {2{store_data[15:0]}};
                load_data  = {{16{is_signed & half_sel[15]}}, half_sel};
            end
            default: begin
                misaligned = |byte_off;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// Pipeline MEM stage: issues loads/stores on a req/ack data bus, stalls the
// pipeline until the bus completes (or times out) and presents a writeback
// bubble while stalled.
module mem_access_stage
    import mem_stage_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [1:0]  MemSize,
    input  logic        MemSigned,
    input  logic        MemToReg,
    input  logic        RegWrite,
    input  logic [31:0] address,
    input  logic [31:0] WriteData,
    input  logic [4:0]  writeReg,
    output logic        MemToRegOut,
    output logic        RegWriteOut,
    output logic [31:0] MemReadData,
    output logic [31:0] addressOut,
    output logic [4:0]  writeRegOut,
    output logic        mem_stall,
    output logic        misalign_err,
    output logic        bus_err,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack
);

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    mem_state_t  state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0] data_q, data_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        bus_err_q, bus_err_d;

    logic        access;
    logic        misaligned;
    logic        start;
    logic [3:0]  lane_be;
    logic [31:0] lane_wdata;
    logic [31:0] lane_rdata;

    // Inputs are frozen while stalled, so live size/offset also format the read data.
    mem_lane_align u_align (
        .byte_off   (address[1:0]),
        .size       (MemSize),
        .is_signed  (MemSigned),
        .store_data (WriteData),
        .load_word  (dmem_rdata),
        .misaligned (misaligned),
        .be         (lane_be),
        .wdata      (lane_wdata),
        .load_data  (lane_rdata)
    );

    assign access = MemRead | MemWrite;
    assign start  = (state_q == IDLE) && access && !misaligned;

    // Next-state and bus-field logic; an ack on the timeout cycle wins.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        data_d    = data_q;
        req_d     = req_q;
        we_d      = we_q;
        be_d      = be_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        bus_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = BUSY;
                    req_d   = 1'b1;
                    we_d    = MemWrite;
                    be_d    = lane_be;
                    addr_d  = {address[31:2], 2'b00};
                    wdata_d = lane_wdata;
                    cnt_d   = '0;
                    data_d  = '0;
                end
            end
            BUSY: begin
                if (dmem_ack) begin
                    data_d  = we_q ? 32'd0 : lane_rdata;
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    state_d = DONE;
                end else if (cnt_q == CNT_LAST) begin
                    data_d    = '0;
                    req_d     = 1'b0;
                    we_d      = 1'b0;
                    bus_err_d = 1'b1;
                    state_d   = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM and registered bus outputs; reset abandons any transaction in flight.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            data_q    <= '0;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            be_q      <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            data_q    <= data_d;
            req_q     <= req_d;
            we_q      <= we_d;
            be_q      <= be_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            bus_err_q <= bus_err_d;
        end
    end

    assign mem_stall    = start || (state_q == BUSY);
    assign misalign_err = (state_q == IDLE) && access && misaligned;
    assign bus_err      = bus_err_q;

    assign dmem_req   = req_q;
    assign dmem_we    = we_q;
    assign dmem_be    = be_q;
    assign dmem_addr  = addr_q;
    assign dmem_wdata = wdata_q;

    // Writeback sees a bubble while stalled or on a rejected access.
    assign RegWriteOut = RegWrite & ~mem_stall & ~misalign_err;
    assign MemToRegOut = MemToReg;
    assign MemReadData = (state_q == DONE) ? data_q : 32'd0;
    assign addressOut  = address;
    assign writeRegOut = writeReg;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage with a scoreboard of expected writeback
// results, pushed when an access is driven and popped when DONE is reached.
module tb_mem_access_stage;

    localparam int TO = 4;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        MemRead, MemWrite, MemSigned, MemToReg, RegWrite;
    logic [1:0]  MemSize;
    logic [31:0] address, WriteData;
    logic [4:0]  writeReg;
    logic        MemToRegOut, RegWriteOut;
    logic [31:0] MemReadData, addressOut;
    logic [4:0]  writeRegOut;
    logic        mem_stall, misalign_err, bus_err;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack;

    typedef struct {
        string       tag;
        logic [31:0] md;
        logic        rw;
        logic [31:0] addr;
        logic [4:0]  wr;
        logic        m2r;
    } exp_t;

    exp_t sb[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    mem_access_stage #(.TIMEOUT(TO)) u_dut (
        .clock(clock), .reset_n(reset_n),
        .MemRead(MemRead), .MemWrite(MemWrite), .MemSize(MemSize),
        .MemSigned(MemSigned), .MemToReg(MemToReg), .RegWrite(RegWrite),
        .address(address), .WriteData(WriteData), .writeReg(writeReg),
        .MemToRegOut(MemToRegOut), .RegWriteOut(RegWriteOut),
        .MemReadData(MemReadData), .addressOut(addressOut),
        .writeRegOut(writeRegOut), .mem_stall(mem_stall),
        .misalign_err(misalign_err), .bus_err(bus_err),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        MemRead = 0; MemWrite = 0; MemSize = 2'b10; MemSigned = 0;
        MemToReg = 0; RegWrite = 0; address = 32'h0; WriteData = 32'h0;
        writeReg = 5'd0;
    endtask

    // One aligned access; k = BUSY cycles before ack (k<0: never ack).
    task automatic run_access(input string tag, input logic rd, input logic wr,
                              input logic [1:0] sz, input logic sg, input logic rw,
                              input logic [31:0] ad, input logic [31:0] wd, input int k,
                              input logic [31:0] rdat, input logic [31:0] exp_md,
                              input logic [3:0] exp_be, input logic [31:0] exp_wd,
                              input logic exp_we);
        exp_t e;
        exp_t got;
        int   stall_cnt = 0;
        int   req_cnt   = 0;
        int   berr_cnt  = 0;
        bit   done      = 0;
        @(posedge clock);
        @(negedge clock);
        MemRead = rd; MemWrite = wr; MemSize = sz; MemSigned = sg;
        MemToReg = rd; RegWrite = rw; address = ad; WriteData = wd;
        writeReg = ad[6:2];
        e.tag = tag; e.md = exp_md; e.rw = rw; e.addr = ad; e.wr = ad[6:2]; e.m2r = rd;
        sb.push_back(e);
        #1;
        for (int n = 0; n < 40; n++) begin
            if (mem_stall) stall_cnt++;
            if (bus_err) berr_cnt++;
            if (dmem_req) begin
                req_cnt++;
                if (req_cnt == 1) begin
                    check({tag, ".be"}, {28'd0, dmem_be}, {28'd0, exp_be});
                    check({tag, ".addr"}, dmem_addr, {ad[31:2], 2'b00});
                    check({tag, ".wdata"}, dmem_wdata, exp_wd);
                    check({tag, ".we"}, {31'd0, dmem_we}, {31'd0, exp_we});
                end
                dmem_ack   = (k >= 0) && (req_cnt == k + 1);
                dmem_rdata = rdat;
            end else begin
                dmem_ack = 1'b0;
            end
            if (!mem_stall && n > 0) begin
                done = 1;
                if (sb.size() == 0) begin
                    n_cmp++; n_fail++;
                    $error("FAIL %s.sb: observed empty scoreboard expected entry", tag);
                end else begin
                    got = sb.pop_front();
                    check({got.tag, ".rdata"}, MemReadData, got.md);
                    check({got.tag, ".regwrite"}, {31'd0, RegWriteOut}, {31'd0, got.rw});
                    check({got.tag, ".addr_out"}, addressOut, got.addr);
                    check({got.tag, ".wreg_out"}, {27'd0, writeRegOut}, {27'd0, got.wr});
                    check({got.tag, ".m2r_out"}, {31'd0, MemToRegOut}, {31'd0, got.m2r});
                end
                break;
            end else begin
                check({tag, ".bubble"}, {31'd0, RegWriteOut}, 32'd0);
            end
            @(posedge clock); #1;
        end
        dmem_ack = 1'b0;
        idle_inputs();
        if (!done) begin
            n_cmp++; n_fail++;
            $error("FAIL %s.timeout: observed no DONE expected DONE within 40 cycles", tag);
        end
        check({tag, ".stall_cycles"}, stall_cnt, (k >= 0) ? k + 2 : TO + 1);
        check({tag, ".req_cycles"}, req_cnt, (k >= 0) ? k + 1 : TO);
        check({tag, ".bus_err"}, berr_cnt, (k >= 0) ? 0 : 1);
    endtask

    task automatic run_misalign(input string tag, input logic [1:0] sz, input logic [31:0] ad);
        @(posedge clock);
        @(negedge clock);
        MemRead = 1; MemWrite = 0; MemSize = sz; MemSigned = 0;
        MemToReg = 1; RegWrite = 1; address = ad; writeReg = 5'd7;
        #1;
        check({tag, ".stall"}, {31'd0, mem_stall}, 32'd0);
        check({tag, ".misalign"}, {31'd0, misalign_err}, 32'd1);
        check({tag, ".regwrite"}, {31'd0, RegWriteOut}, 32'd0);
        check({tag, ".rdata"}, MemReadData, 32'd0);
        @(posedge clock); #1;
        idle_inputs();
        #1;
        check({tag, ".req"}, {31'd0, dmem_req}, 32'd0);
        check({tag, ".misalign_drop"}, {31'd0, misalign_err}, 32'd0);
    endtask

    initial begin
        idle_inputs();
        dmem_ack = 0; dmem_rdata = 32'h0;
        reset_n = 0;
        address = 32'h0000_0ABC;
        #12;
        check("rst.req", {31'd0, dmem_req}, 32'd0);
        check("rst.we", {31'd0, dmem_we}, 32'd0);
        check("rst.be", {28'd0, dmem_be}, 32'd0);
        check("rst.addr", dmem_addr, 32'd0);
        check("rst.wdata", dmem_wdata, 32'd0);
        check("rst.bus_err", {31'd0, bus_err}, 32'd0);
        check("rst.rdata", MemReadData, 32'd0);
        check("rst.addr_pass", addressOut, 32'h0000_0ABC);
        @(negedge clock);
        reset_n = 1;
        idle_inputs();

        //          tag      rd wr sz     sg rw addr          wdata         k  rdata         exp_md        be       exp_wd        we
        run_access("lw",     1, 0, 2'b10, 0, 1, 32'h100, 32'h0,        3, 32'hDEADBEEF, 32'hDEADBEEF, 4'b1111, 32'h0,        0);
        run_access("lb",     1, 0, 2'b00, 1, 1, 32'h103, 32'h0,        0, 32'h80FF7F01, 32'hFFFFFF80, 4'b1000, 32'h0,        0);
        run_access("lbu",    1, 0, 2'b00, 0, 1, 32'h103, 32'h0,        1, 32'h80FF7F01, 32'h00000080, 4'b1000, 32'h0,        0);
        run_access("lh",     1, 0, 2'b01, 1, 1, 32'h102, 32'h0,        2, 32'h80FF7F01, 32'hFFFF80FF, 4'b1100, 32'h0,        0);
        run_access("lhu",    1, 0, 2'b01, 0, 1, 32'h100, 32'h0,        0, 32'h80FF7F01, 32'h00007F01, 4'b0011, 32'h0,        0);
        run_access("sh",     0, 1, 2'b01, 0, 0, 32'h102, 32'h1234ABCD, 1, 32'h55555555, 32'h0,        4'b1100, 32'hABCDABCD, 1);
        run_access("sb",     0, 1, 2'b00, 0, 0, 32'h101, 32'h000000A5, 0, 32'h55555555, 32'h0,        4'b0010, 32'hA5A5A5A5, 1);
        run_access("lw_sz3", 1, 0, 2'b11, 1, 1, 32'h104, 32'h0,        0, 32'hCAFEF00D, 32'hCAFEF00D, 4'b1111, 32'h0,        0);
        run_access("rdwr",   1, 1, 2'b10, 0, 0, 32'h108, 32'h11223344, 2, 32'h99999999, 32'h0,        4'b1111, 32'h11223344, 1);
        run_misalign("mis_lw", 2'b10, 32'h102);
        run_misalign("mis_lh", 2'b01, 32'h101);
        run_access("tmo",    1, 0, 2'b10, 0, 1, 32'h10C, 32'h0,       -1, 32'h12345678, 32'h0,        4'b1111, 32'h0,        0);

        // Reset during BUSY abandons the transaction.
        @(posedge clock);
        @(negedge clock);
        MemRead = 1; MemSize = 2'b10; RegWrite = 1; MemToReg = 1; address = 32'h110;
        @(posedge clock); #1;
        check("rstbusy.req_before", {31'd0, dmem_req}, 32'd1);
        #2;
        reset_n = 0;
        #1;
        check("rstbusy.req_after", {31'd0, dmem_req}, 32'd0);
        check("rstbusy.rdata", MemReadData, 32'd0);
        idle_inputs();
        @(negedge clock);
        reset_n = 1;
        run_access("lw_post", 1, 0, 2'b10, 0, 1, 32'h114, 32'h0, 0, 32'h0F0F1234, 32'h0F0F1234, 4'b1111, 32'h0, 0);

        check("sb.drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Pipeline MEM stage between the EX/MEM register and the MEM/WB register. It performs loads and stores to data memory over a req/ack bus with variable latency, aligns byte, halfword and word data, and stalls the pipeline until the access completes. Its outputs feed the MEM/WB register directly. During a stall it presents a bubble (RegWrite forced low), so writeback never sees a duplicate write.

## Interface
Parameters:
- TIMEOUT, 255: maximum BUSY cycles to wait for dmem_ack before aborting with bus_err.

Ports:
- clock  in  1  pipeline clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- MemRead, MemWrite  in  1  access request from EX/MEM. Both high at once is illegal; it is treated as a write.
- MemSize  in  2  00 byte, 01 half, 10 word; 11 is treated as word.
- MemSigned  in  1  sign-extend byte/half loads when 1.
- MemToReg, RegWrite  in  1  control bits passed through.
- address  in  32  effective address from the ALU.
- WriteData  in  32  store data (low byte/half used for sb/sh).
- writeReg  in  5  destination register passed through.
- MemToRegOut, RegWriteOut  out  1  to MEM/WB. RegWriteOut is 0 while mem_stall=1 or on a misaligned access.
- MemReadData  out  32  aligned, extended load data.
- addressOut  out  32  address passed through (ALU result path).
- writeRegOut  out  5  passed through.
- mem_stall  out  1  to hazard unit; freezes PC and IF/ID, ID/EX and EX/MEM.
- misalign_err, bus_err  out  1  one-cycle error pulses.
- dmem_req, dmem_we  out  1  bus request, write enable.
- dmem_addr  out  32  word address ({address[31:2],2'b00}).
- dmem_be  out  4  byte enables.
- dmem_wdata  out  32  lane-replicated store data.
- dmem_rdata  in  32  read data, valid with dmem_ack.
- dmem_ack  in  1  one-cycle completion strobe.

## Operation
- Byte order is little-endian: byte k occupies bits [8k+7:8k] and is selected by address[1:0].
- An access is MemRead|MemWrite.
- Misalignment: a half access with address[0]=1, or a word access with address[1:0]≠0. A misaligned access has no bus cycle, no stall, a misalign_err pulse, RegWriteOut=0 and MemReadData=0.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: on an aligned access, latch the bus fields and go to BUSY. mem_stall=1 combinationally in that cycle. A non-access passes through with no stall.
  - BUSY: dmem_req=1 and the bus fields are held stable. The wait counter increments each cycle.
    - On dmem_ack: capture the formatted rdata (loads), go to DONE.
    - If the counter reaches TIMEOUT without ack: drop dmem_req, pulse bus_err, set the data register to 0, go to DONE.
  - DONE: mem_stall=0 and outputs valid; the pipeline advances at this edge. Next state is IDLE.
- Store enables:
  - byte: be = 1<<address[1:0], wdata = {4{WriteData[7:0]}}.
  - half: be = 0011 or 1100, wdata = {2{WriteData[15:0]}}.
  - word: be = 1111.
- Load format: extract the lane, then zero- or sign-extend per MemSigned. Word loads ignore MemSigned.
- MemReadData equals the data register in DONE and 0 otherwise.
- Stores and timeouts in DONE yield MemReadData=0. RegWriteOut passes through (stores arrive with RegWrite=0).

## Timing
- Reset values: state IDLE, counter 0, data register 0, dmem_req=0, dmem_we=0, dmem_be=0, dmem_addr=0, dmem_wdata=0, error pulses 0. Pass-through outputs follow the inputs.
- Latency for an aligned access with ack k cycles after the request (k≥0 in the first BUSY cycle):
  - access seen in cycle 0;
  - dmem_req asserted from cycle 1;
  - DONE in cycle 2+k;
  - mem_stall high for cycles 0 through 1+k.
- dmem_ack is ignored in IDLE and DONE. An ack arriving on the same edge as the timeout counts as an ack: no bus_err.
- Back-to-back accesses: DONE always returns to IDLE for at least one cycle, so the next instruction's access starts in that IDLE cycle.
- reset_n low mid-BUSY immediately drops dmem_req and forces IDLE; the transaction is abandoned.
- The inputs are held stable by the pipeline freeze while mem_stall=1.

## Structure
- Package mem_stage_pkg holds:
  - size encodings SZ_BYTE, SZ_HALF and SZ_WORD;
  - the state enum mem_state_t {IDLE, BUSY, DONE};
  - the default TIMEOUT.
- Sub-module mem_lane_align is combinational and handles both directions:
  - loads: lane extract and extension;
  - stores: byte-enable and wdata replication.
  It is instantiated once. The FSM, counter and data register live in the top.

## Test plan
- lw at 0x100, ack 3 cycles after req, rdata 0xDEADBEEF -> dmem_be=1111, mem_stall for 5 cycles, MemReadData=0xDEADBEEF with RegWriteOut=1 only in DONE.
- lb signed at 0x103, rdata 0x80FF7F01 -> MemReadData=0xFFFFFF80. Same access with lbu -> 0x00000080.
- sh at 0x102, WriteData 0x1234ABCD -> dmem_be=1100, dmem_wdata=0xABCDABCD, dmem_we=1, dmem_addr=0x100.
- lw at 0x102 -> no dmem_req, no stall, misalign_err pulse, RegWriteOut=0.
- TIMEOUT=4, no ack -> dmem_req for 4 cycles, bus_err pulse, MemReadData=0.
- reset_n low during BUSY -> dmem_req=0 immediately. After release, state is IDLE and a new lw completes normally.
